io_bus_arbiter: RTL

//  Shares the single memory_io access port (address_io/data_in_io/control_io -> data_out_io) between two

---
 rtl/io_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// io_bus_arbiter : round-robin sharing of the memory_io port between two
//                  requesters, with in-order read-return tracking.
// Rev 1.0
// ============================================================================
module io_bus_arbiter #(
   parameter int READ_LATENCY = 2
) (
   input  logic        main_clk,
   input  logic        main_rst_n,
   input  logic        req_0,
   input  logic        req_1,
   input  logic [31:0] addr_0,
   input  logic [31:0] addr_1,
   input  logic [15:0] wdata_0,
   input  logic [15:0] wdata_1,
   input  logic        is_write_0,
   input  logic        is_write_1,
   input  logic        is_byte_0,
   input  logic        is_byte_1,
   output logic        ack_0,
   output logic        ack_1,
   output logic        rvalid_0,
   output logic        rvalid_1,
   output logic [15:0] rdata_0,
   output logic [15:0] rdata_1,
   output logic [31:0] address_io,
   output logic [15:0] data_in_io,
   output logic [1:0]  control_io,
   input  logic [15:0] data_out_io
);

   localparam int c_DEPTH = READ_LATENCY + 1;

   logic               w_grant_0;
   logic               w_grant_1;
   logic               w_ret_valid;
   logic               w_ret_owner;

   logic               prio_q,      prio_d;
   logic [31:0]        address_q,   address_d;
   logic [15:0]        data_in_q,   data_in_d;
   logic [1:0]         control_q,   control_d;
   logic [c_DEPTH-1:0] trk_valid_q, trk_valid_d;
   logic [c_DEPTH-1:0] trk_owner_q, trk_owner_d;
   logic               rvalid0_q,   rvalid0_d;
   logic               rvalid1_q,   rvalid1_d;
   logic [15:0]        rdata0_q,    rdata0_d;
   logic [15:0]        rdata1_q,    rdata1_d;

   // prio_q names the port that wins a tie; no grants while reset is held
   always_comb begin
      w_grant_0 = 1'b0;
      w_grant_1 = 1'b0;
      if (main_rst_n) begin
         if (req_0 && req_1) begin
            w_grant_0 = ~prio_q;
            w_grant_1 = prio_q;
         end else begin
            w_grant_0 = req_0;
            w_grant_1 = req_1;
         end
      end
   end

   always_comb begin
      prio_d    = prio_q;
      address_d = '0;
      data_in_d = '0;
      control_d = '0;
      if (w_grant_0) begin
         prio_d    = 1'b1;
         address_d = addr_0;
         data_in_d = wdata_0;
         control_d = {is_write_0, is_byte_0};
      end else if (w_grant_1) begin
         prio_d    = 1'b0;
         address_d = addr_1;
         data_in_d = wdata_1;
         control_d = {is_write_1, is_byte_1};
      end
   end

   // Entry 0 is the access on the IO port now; the last entry lines up with
   // the cycle in which memory_io presents its read data.
   always_comb begin
      trk_valid_d[0] = (w_grant_0 & ~is_write_0) | (w_grant_1 & ~is_write_1);
      trk_owner_d[0] = w_grant_1;
      for (int i = 1; i < c_DEPTH; i++) begin
         trk_valid_d[i] = trk_valid_q[i-1];
         trk_owner_d[i] = trk_owner_q[i-1];
      end
   end

   assign w_ret_valid = trk_valid_q[c_DEPTH-1];
   assign w_ret_owner = trk_owner_q[c_DEPTH-1];

   always_comb begin
      rvalid0_d = w_ret_valid & ~w_ret_owner;
      rvalid1_d = w_ret_valid &  w_ret_owner;
      rdata0_d  = rvalid0_d ? data_out_io : rdata0_q;
      rdata1_d  = rvalid1_d ? data_out_io : rdata1_q;
   end

   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         prio_q      <= 1'b0;
         address_q   <= '0;
         data_in_q   <= '0;
         control_q   <= '0;
         trk_valid_q <= '0;
         trk_owner_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         prio_q      <= prio_d;
         address_q   <= address_d;
         data_in_q   <= data_in_d;
         control_q   <= control_d;
         trk_valid_q <= trk_valid_d;
         trk_owner_q <= trk_owner_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign ack_0      = w_grant_0;
   assign ack_1      = w_grant_1;
   assign rvalid_0   = rvalid0_q;
   assign rvalid_1   = rvalid1_q;
   assign rdata_0    = rdata0_q;
   assign rdata_1    = rdata1_q;
   assign address_io = address_q;
   assign data_in_io = data_in_q;
   assign control_io = control_q;

endmodule
`default_nettype wire
